// File: rtl/local_branch_predictor.sv
// Local-history branch direction predictor: per-PC history table (BHT) indexing a
// shared table of 2-bit saturating counters (PHT), plus resolved/mispredict counters.
module local_branch_predictor #(
  parameter int BHT_IDX_W = 6,
  parameter int HIST_LEN  = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        update_en,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic        update_pred,
  output logic        pred_takeF,
  output logic        pred_takeD,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int BHT_N = 1 << BHT_IDX_W;
  localparam int PHT_N = 1 << HIST_LEN;
  localparam logic [1:0] CTR_WEAK_NT = 2'b01;

  logic [HIST_LEN-1:0] bht_q [BHT_N];
  logic [HIST_LEN-1:0] bht_d [BHT_N];
  logic [1:0]          pht_q [PHT_N];
  logic [1:0]          pht_d [PHT_N];
  logic                pred_decode_q, pred_decode_d;
  logic [31:0]         branch_count_q, branch_count_d;
  logic [31:0]         mispredict_count_q, mispredict_count_d;

  logic [BHT_IDX_W-1:0] fetch_idx, upd_idx;
  logic [HIST_LEN-1:0]  fetch_hist, upd_hist;
  logic [1:0]           upd_ctr, upd_ctr_next;

  // PC bits outside the index field carry no information for this table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pcF[31:BHT_IDX_W+2], pcF[1:0],
                            update_pc[31:BHT_IDX_W+2], update_pc[1:0]};

  // Lookup reads only the registered tables, so a same-cycle update is never bypassed.
  always_comb begin
    fetch_idx  = pcF[BHT_IDX_W+1:2];
    fetch_hist = bht_q[fetch_idx];
    pred_takeF = pht_q[fetch_hist][1];
  end

  always_comb begin
    upd_idx  = update_pc[BHT_IDX_W+1:2];
    upd_hist = bht_q[upd_idx];
    upd_ctr  = pht_q[upd_hist];
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    upd_ctr_next = upd_ctr;
    if (update_taken && (upd_ctr != 2'b11)) begin
      upd_ctr_next = upd_ctr + 2'd1;
    end else if (!update_taken && (upd_ctr != 2'b00)) begin
      upd_ctr_next = upd_ctr - 2'd1;
    end
  end

  always_comb begin
    bht_d              = bht_q;
    pht_d              = pht_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (update_en) begin
      pht_d[upd_hist]    = upd_ctr_next;
      bht_d[upd_idx]     = {upd_hist[HIST_LEN-2:0], update_taken};
      branch_count_d     = branch_count_q + 32'd1;
      if (update_taken != update_pred) begin
        mispredict_count_d = mispredict_count_q + 32'd1;
      end
    end
  end

  always_comb begin
    pred_decode_d = pred_decode_q;
    if (flushD) begin
      pred_decode_d = 1'b0;
    end else if (!stallD) begin
      pred_decode_d = pred_takeF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the tables are reset explicitly; predictions must be defined from the first fetch, so they cannot map to reset-less RAM.
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= '0;
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= CTR_WEAK_NT;
      pred_decode_q      <= 1'b0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      bht_q              <= bht_d;
      pht_q              <= pht_d;
      pred_decode_q      <= pred_decode_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign pred_takeD       = pred_decode_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_local_branch_predictor.sv
// Self-checking bench for local_branch_predictor: directed vector table for the
// documented scenarios, then randomized traffic against an arithmetic reference model.
module tb_local_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcF;
  logic        stallD, flushD;
  logic        update_en;
  logic [31:0] update_pc;
  logic        update_taken, update_pred;
  logic        pred_takeF, pred_takeD;
  logic [31:0] branch_count, mispredict_count;

  local_branch_predictor #(.BHT_IDX_W(6), .HIST_LEN(6)) dut (
    .clk              (clk),
    .rst              (rst),
    .pcF              (pcF),
    .stallD           (stallD),
    .flushD           (flushD),
    .update_en        (update_en),
    .update_pc        (update_pc),
    .update_taken     (update_taken),
    .update_pred      (update_pred),
    .pred_takeF       (pred_takeF),
    .pred_takeD       (pred_takeD),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic        uen;
    logic [31:0] upc;
    logic        utaken;
    logic        upred;
    logic        chk_f;
    logic        exp_f;
    logic        exp_d;
    logic [31:0] exp_bc;
    logic [31:0] exp_mc;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [31:0] pc, input logic st, input logic fl,
                       input logic ue, input logic [31:0] upc, input logic ut, input logic up);
    rst = r; pcF = pc; stallD = st; flushD = fl;
    update_en = ue; update_pc = upc; update_taken = ut; update_pred = up;
  endtask

  // Reference model: histories as integers 0..63, counters as integers 0..3.
  int          m_bht [64];
  int          m_pht [64];
  int unsigned m_bc, m_mc;
  bit          m_pred_d;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  function automatic bit model_pred(input logic [31:0] pc);
    return m_pht[m_bht[idx_of(pc)]] >= 2;
  endfunction

  task automatic model_edge(input bit r, input logic [31:0] pc, input bit st, input bit fl,
                            input bit ue, input logic [31:0] upc, input bit ut, input bit up);
    bit pf;
    int i, h;
    pf = model_pred(pc);
    if (r) begin
      for (int k = 0; k < 64; k++) begin m_bht[k] = 0; m_pht[k] = 1; end
      m_bc = 0; m_mc = 0; m_pred_d = 0;
    end else begin
      if (fl) m_pred_d = 0;
      else if (!st) m_pred_d = pf;
      if (ue) begin
        i = idx_of(upc);
        h = m_bht[i];
        if (ut) m_pht[h] = (m_pht[h] == 3) ? 3 : m_pht[h] + 1;
        else    m_pht[h] = (m_pht[h] == 0) ? 0 : m_pht[h] - 1;
        m_bht[i] = (h * 2 + (ut ? 1 : 0)) % 64;
        m_bc++;
        if (ut != up) m_mc++;
      end
    end
  endtask

  vec_t vecs[$];

  initial begin
    drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    //             rst  pc            st    fl    uen   upc       ut    up    chkF  expF  expD  bc     mc
    vecs.push_back('{1'b1, 32'h10,       1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0});
    vecs.push_back('{1'b0, 32'h10,       1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 32'd1});
    vecs.push_back('{1'b0, 32'h10,       1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 32'd1});
    for (int k = 2; k <= 7; k++)
      vecs.push_back('{1'b0, 32'h10,     1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'(k), 32'(k)});
    vecs.push_back('{1'b0, 32'h10,       1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd7, 32'd7});
    vecs.push_back('{1'b0, 32'h10,       1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'd8, 32'd7});
    vecs.push_back('{1'b0, 32'h20,       1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'd9, 32'd8});
    vecs.push_back('{1'b0, 32'h20,       1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd9, 32'd8});
    vecs.push_back('{1'b0, 32'h10,       1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd9, 32'd8});
    vecs.push_back('{1'b0, 32'h20,       1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd9, 32'd8});
    vecs.push_back('{1'b0, 32'h10,       1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd9, 32'd8});
    vecs.push_back('{1'b0, 32'h10,       1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd9, 32'd8});
    vecs.push_back('{1'b0, 32'h10,       1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd9, 32'd8});
    vecs.push_back('{1'b0, 32'h10,       1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd9, 32'd8});
    vecs.push_back('{1'b0, 32'h10,       1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'd10, 32'd9});
    vecs.push_back('{1'b1, 32'h10,       1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0});
    vecs.push_back('{1'b0, 32'h10,       1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0});
    vecs.push_back('{1'b0, 32'h20,       1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0});
    vecs.push_back('{1'b0, 32'h10,       1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd1, 32'd0});
    vecs.push_back('{1'b0, 32'hFFFFFF43, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd1, 32'd0});
    vecs.push_back('{1'b0, 32'h113,      1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1, 32'd0});

    @(posedge clk); #1;
    foreach (vecs[n]) begin
      drive(vecs[n].rst, vecs[n].pc, vecs[n].stall, vecs[n].flush,
            vecs[n].uen, vecs[n].upc, vecs[n].utaken, vecs[n].upred);
      #1;
      if (vecs[n].chk_f) check($sformatf("vec%0d pred_takeF", n), 32'(pred_takeF), 32'(vecs[n].exp_f));
      @(posedge clk); #1;
      check($sformatf("vec%0d pred_takeD", n), 32'(pred_takeD), 32'(vecs[n].exp_d));
      check($sformatf("vec%0d branch_count", n), branch_count, vecs[n].exp_bc);
      check($sformatf("vec%0d mispredict_count", n), mispredict_count, vecs[n].exp_mc);
    end

    // Randomized traffic: a small PC pool forces aliasing, high/low PC bits are noise.
    for (int c = 0; c < 3000; c++) begin
      bit          r, st, fl, ue, ut, up;
      logic [31:0] pc, upc;
      r   = (c == 0) || ($urandom_range(0, 299) == 0);
      st  = ($urandom_range(0, 7) == 0);
      fl  = ($urandom_range(0, 15) == 0);
      ue  = ($urandom_range(0, 2) != 0);
      ut  = ($urandom_range(0, 3) != 0);
      up  = $urandom_range(0, 1);
      pc  = {$urandom_range(0, 3), 20'h0, 4'(0), 8'(0)} | (32'($urandom_range(0, 95)) << 2) | 32'($urandom_range(0, 3));
      upc = ($urandom_range(0, 1) ? pc : (32'($urandom_range(0, 95)) << 2)) ^ (32'($urandom_range(0, 15)) << 12);
      drive(r, pc, st, fl, ue, upc, ut, up);
      #1;
      if (c != 0) check($sformatf("rnd%0d pred_takeF", c), 32'(pred_takeF), 32'(model_pred(pc)));
      model_edge(r, pc, st, fl, ue, upc, ut, up);
      @(posedge clk); #1;
      check($sformatf("rnd%0d pred_takeD", c), 32'(pred_takeD), 32'(m_pred_d));
      check($sformatf("rnd%0d branch_count", c), branch_count, m_bc);
      check($sformatf("rnd%0d mispredict_count", c), mispredict_count, m_mc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
